// File: rtl/sram_region.sv
// Generic on-chip SRAM region on a valid/ready request/response bus.
// Byte-enable writes, misaligned-access errors, programmable wait states and response backpressure.
module sram_region #(
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter int unsigned SIZE_BYTES  = 98304,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        hit,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int unsigned DEPTH    = SIZE_BYTES / 4;
   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW       = 4;
   localparam int unsigned LANES    = 4;
   localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;
   // 33-bit limit so a region ending at the top of the address space does not wrap
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(SIZE_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state, state_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic [31:0]     data_q, data_d;
   logic            err_q, err_d;
   logic            rsp_valid_d;
   logic [31:0]     rsp_rdata_d;
   logic            rsp_error_d;

   logic [31:0]     mem [DEPTH];
   logic [31:0]     offset;
   logic [AW-1:0]   word_idx;
   logic [31:0]     rd_word;
   logic            aligned;
   logic            accept;
   logic            wr_en;

   // Address decode and byte-to-word translation
   always_comb begin
      offset   = req_addr - BASE_ADDR;
      word_idx = AW'(offset >> 2);
      hit      = (req_addr >= BASE_ADDR) && ({1'b0, req_addr} < LIMIT);
      aligned  = (req_addr[1:0] == 2'b00);
      rd_word  = mem[word_idx];
   end

   assign req_ready = (state == IDLE) && hit;
   assign accept    = req_valid && req_ready && !reset;

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      data_d      = data_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_error_d = 1'b0;
      wr_en       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               err_d  = !aligned;
               data_d = (aligned && !req_write) ? rd_word : '0;
               wr_en  = aligned && req_write;
               if (WAIT_STATES == 0) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = data_d;
                  rsp_error_d = err_d;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = data_q;
               rsp_error_d = err_q;
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rsp_rdata;
               rsp_error_d = rsp_error;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and response registers; reset drops any transaction in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         data_q    <= data_d;
         err_q     <= err_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_error <= rsp_error_d;
      end
   end

   // Storage array is never reset; writes commit on the accept edge
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (req_be[i]) begin
               mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_region.sv
// Directed bench for sram_region: three instances cover default decode, wait states and a small region.
module tb_sram_region;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        hit;
      logic        acc;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   logic        clk;
   logic        reset     [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_write [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic        hit       [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_error [3];

   int checks;
   int failures;

   sram_region #(.BASE_ADDR(32'h2000_0000), .SIZE_BYTES(98304), .WAIT_STATES(0)) u_ws0 (
      .clock(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .hit(hit[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));

   sram_region #(.BASE_ADDR(32'h2000_0000), .SIZE_BYTES(98304), .WAIT_STATES(3)) u_ws3 (
      .clock(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .hit(hit[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));

   sram_region #(.BASE_ADDR(32'h1000_0000), .SIZE_BYTES(64), .WAIT_STATES(0)) u_small (
      .clock(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
      .hit(hit[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
      .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic h, input logic acc,
                               input logic [31:0] rdata, input logic err);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
      v.hit = h; v.acc = acc; v.rdata = rdata; v.err = err;
      return v;
   endfunction

   // One request on instance d; checks decode, acceptance, latency, response and return to idle
   task automatic txn(input int d, input int ws, input vec_t v, input string nm);
      int cyc;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_write[d] = v.wr;
      req_addr[d]  = v.addr;
      req_wdata[d] = v.wdata;
      req_be[d]    = v.be;
      #1;
      chk({nm, ".hit"}, 32'(hit[d]), 32'(v.hit));
      chk({nm, ".req_ready"}, 32'(req_ready[d]), 32'(v.acc));
      if (v.acc) begin
         @(negedge clk);
         req_valid[d] = 1'b0;
         cyc = 0;
         while (rsp_valid[d] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         chk({nm, ".latency"}, 32'(cyc), 32'(ws));
         chk({nm, ".rdata"}, rsp_rdata[d], v.rdata);
         chk({nm, ".error"}, 32'(rsp_error[d]), 32'(v.err));
         rsp_ready[d] = 1'b1;
         @(negedge clk);
         rsp_ready[d] = 1'b0;
         chk({nm, ".idle_rsp"}, {rsp_rdata[d][30:0], rsp_valid[d]} | 32'(rsp_error[d]), 32'h0);
      end else begin
         cyc = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b0) cyc++;
         end
         req_valid[d] = 1'b0;
         chk({nm, ".no_rsp"}, 32'(cyc), 32'h0);
      end
   endtask

   vec_t vecs [16];

   initial begin
      int cyc;
      vec_t v;
      checks   = 0;
      failures = 0;

      vecs[0]  = mk(1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1, 32'h0, 0);
      vecs[1]  = mk(0, 32'h2000_0010, 32'h0,         4'h0, 1, 1, 32'hDEAD_BEEF, 0);
      vecs[2]  = mk(1, 32'h2000_0020, 32'h1122_3344, 4'hF, 1, 1, 32'h0, 0);
      vecs[3]  = mk(1, 32'h2000_0020, 32'hAABB_CCDD, 4'h5, 1, 1, 32'h0, 0);
      vecs[4]  = mk(0, 32'h2000_0020, 32'h0,         4'h0, 1, 1, 32'h11BB_33DD, 0);
      vecs[5]  = mk(1, 32'h2001_7FFC, 32'h1234_5678, 4'hF, 1, 1, 32'h0, 0);
      vecs[6]  = mk(0, 32'h2001_7FFC, 32'h0,         4'hF, 1, 1, 32'h1234_5678, 0);
      vecs[7]  = mk(0, 32'h2001_8000, 32'h0,         4'hF, 0, 0, 32'h0, 0);
      vecs[8]  = mk(0, 32'h1FFF_FFFC, 32'h0,         4'hF, 0, 0, 32'h0, 0);
      vecs[9]  = mk(0, 32'h2000_0002, 32'h0,         4'hF, 1, 1, 32'h0, 1);
      vecs[10] = mk(1, 32'h2000_0000, 32'h00C0_FFEE, 4'hF, 1, 1, 32'h0, 0);
      vecs[11] = mk(1, 32'h2000_0001, 32'hFFFF_FFFF, 4'hF, 1, 1, 32'h0, 1);
      vecs[12] = mk(0, 32'h2000_0000, 32'h0,         4'hF, 1, 1, 32'h00C0_FFEE, 0);
      vecs[13] = mk(0, 32'h2001_7FFE, 32'h0,         4'hF, 1, 1, 32'h0, 1);
      vecs[14] = mk(1, 32'h2000_0010, 32'h0000_0000, 4'h0, 1, 1, 32'h0, 0);
      vecs[15] = mk(0, 32'h2000_0010, 32'h0,         4'hF, 1, 1, 32'hDEAD_BEEF, 0);

      for (int d = 0; d < 3; d++) begin
         reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
         req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) reset[d] = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset%0d.valid", d), 32'(rsp_valid[d]), 32'h0);
         chk($sformatf("reset%0d.rdata", d), rsp_rdata[d], 32'h0);
         chk($sformatf("reset%0d.error", d), 32'(rsp_error[d]), 32'h0);
      end

      for (int i = 0; i < 16; i++) txn(0, 0, vecs[i], $sformatf("v%0d", i));

      // Request presented during reset must not be accepted or written
      txn(0, 0, mk(1, 32'h2000_0030, 32'h0102_0304, 4'hF, 1, 1, 32'h0, 0), "rst_pre_wr");
      @(negedge clk);
      reset[0] = 1'b1;
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h2000_0030;
      req_wdata[0] = 32'hFFFF_FFFF; req_be[0] = 4'hF;
      @(negedge clk);
      reset[0] = 1'b0; req_valid[0] = 1'b0;
      chk("rst_req.valid", 32'(rsp_valid[0]), 32'h0);
      @(negedge clk);
      chk("rst_req.valid2", 32'(rsp_valid[0]), 32'h0);
      txn(0, 0, mk(0, 32'h2000_0030, 32'h0, 4'hF, 1, 1, 32'h0102_0304, 0), "rst_req_rd");

      // Wait states with response backpressure, and no accept during RESP
      txn(1, 3, mk(1, 32'h2000_0008, 32'h5A5A_1234, 4'hF, 1, 1, 32'h0, 0), "bp_wr");
      @(negedge clk);
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h2000_0008; req_be[1] = 4'h0;
      #1 chk("bp.ready", 32'(req_ready[1]), 32'h1);
      @(negedge clk);
      req_valid[1] = 1'b0;
      cyc = 0;
      while (rsp_valid[1] !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp.latency", 32'(cyc), 32'd3);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp.hold%0d.valid", k), 32'(rsp_valid[1]), 32'h1);
         chk($sformatf("bp.hold%0d.rdata", k), rsp_rdata[1], 32'h5A5A_1234);
         chk($sformatf("bp.hold%0d.error", k), 32'(rsp_error[1]), 32'h0);
         @(negedge clk);
      end
      rsp_ready[1] = 1'b1;
      req_valid[1] = 1'b1;
      #1 chk("bp.no_accept_in_resp", 32'(req_ready[1]), 32'h0);
      @(negedge clk);
      rsp_ready[1] = 1'b0;
      #1;
      chk("bp.after_hs.valid", 32'(rsp_valid[1]), 32'h0);
      chk("bp.after_hs.ready", 32'(req_ready[1]), 32'h1);
      @(negedge clk);
      req_valid[1] = 1'b0;
      cyc = 0;
      while (rsp_valid[1] !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp2.latency", 32'(cyc), 32'd3);
      chk("bp2.rdata", rsp_rdata[1], 32'h5A5A_1234);
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      rsp_ready[1] = 1'b0;
      chk("bp2.idle", 32'(rsp_valid[1]), 32'h0);

      // Reset two cycles after accepting a write drops the response but keeps the write
      @(negedge clk);
      req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h2000_0040;
      req_wdata[1] = 32'h0000_CAFE; req_be[1] = 4'hF;
      #1 chk("rst_mid.ready", 32'(req_ready[1]), 32'h1);
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      reset[1] = 1'b1;
      @(negedge clk);
      reset[1] = 1'b0;
      chk("rst_mid.valid", 32'(rsp_valid[1]), 32'h0);
      cyc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid[1] !== 1'b0) cyc++;
      end
      chk("rst_mid.no_rsp", 32'(cyc), 32'h0);
      txn(1, 3, mk(0, 32'h2000_0040, 32'h0, 4'hF, 1, 1, 32'h0000_CAFE, 0), "rst_mid_rd");

      // Small overridden region: decode limits and unaliased contents
      txn(2, 0, mk(0, 32'h1000_0040, 32'h0, 4'hF, 0, 0, 32'h0, 0), "small_miss_hi");
      txn(2, 0, mk(0, 32'h0FFF_FFFC, 32'h0, 4'hF, 0, 0, 32'h0, 0), "small_miss_lo");
      for (int i = 0; i < 16; i++) begin
         v = mk(1, 32'h1000_0000 + 32'(4 * i), 32'hC3C3_0000 ^ (32'(i) * 32'h0101_0101), 4'hF,
                1, 1, 32'h0, 0);
         txn(2, 0, v, $sformatf("small_wr%0d", i));
      end
      for (int i = 0; i < 16; i++) begin
         v = mk(0, 32'h1000_0000 + 32'(4 * i), 32'h0, 4'hF,
                1, 1, 32'hC3C3_0000 ^ (32'(i) * 32'h0101_0101), 0);
         txn(2, 0, v, $sformatf("small_rd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
